axis_sw_remote: RTL and testbench

//  Far-end (FPGA-side) counterpart of the on-chip AXI-Stream switch, sitting behind the remote IO serdes.

---
 rtl/axis_sw_remote.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_axis_sw_remote.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sw_remote.sv
// Far-end AXI-Stream switch: tid-demuxed ingress FIFO toward UP/AA/LA and a round-robin UP/AA link arbiter.
// Optional build macro AXIS_SW_RMT_DROP_CNT_EN adds the ds_drop_cnt port (saturating tid-11 discard count).
module axis_sw_remote #(
   parameter int pUSER_PROJECT_SIDEBAND_WIDTH = 5,
   parameter int pDATA_WIDTH                  = 32,
   parameter int pFIFO_DEPTH                  = 8,
   parameter int pMAX_BEAT                    = 8
) (
   input  logic                                    axis_clk,
   input  logic                                    axi_reset,
   input  logic [pDATA_WIDTH-1:0]                  is_as_tdata,
   input  logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] is_as_tupsb,
   input  logic [pDATA_WIDTH/8-1:0]                is_as_tstrb,
   input  logic [pDATA_WIDTH/8-1:0]                is_as_tkeep,
   input  logic                                    is_as_tlast,
   input  logic [1:0]                              is_as_tid,
   input  logic [1:0]                              is_as_tuser,
   input  logic                                    is_as_tvalid,
   output logic                                    as_is_tready,
   output logic [pDATA_WIDTH-1:0]                  as_up_tdata,
   output logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] as_up_tupsb,
   output logic [pDATA_WIDTH/8-1:0]                as_up_tstrb,
   output logic [pDATA_WIDTH/8-1:0]                as_up_tkeep,
   output logic                                    as_up_tlast,
   output logic [1:0]                              as_up_tuser,
   output logic                                    as_up_tvalid,
   input  logic                                    up_as_tready,
   output logic [pDATA_WIDTH-1:0]                  as_aa_tdata,
   output logic [pDATA_WIDTH/8-1:0]                as_aa_tstrb,
   output logic [pDATA_WIDTH/8-1:0]                as_aa_tkeep,
   output logic                                    as_aa_tlast,
   output logic [1:0]                              as_aa_tuser,
   output logic                                    as_aa_tvalid,
   input  logic                                    aa_as_tready,
   output logic [pDATA_WIDTH-1:0]                  as_la_tdata,
   output logic [pDATA_WIDTH/8-1:0]                as_la_tstrb,
   output logic [pDATA_WIDTH/8-1:0]                as_la_tkeep,
   output logic                                    as_la_tlast,
   output logic [1:0]                              as_la_tuser,
   output logic                                    as_la_tvalid,
   input  logic                                    la_as_tready,
   input  logic [pDATA_WIDTH-1:0]                  up_as_tdata,
   input  logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] up_as_tupsb,
   input  logic [pDATA_WIDTH/8-1:0]                up_as_tstrb,
   input  logic [pDATA_WIDTH/8-1:0]                up_as_tkeep,
   input  logic                                    up_as_tlast,
   input  logic [1:0]                              up_as_tuser,
   input  logic                                    up_as_tvalid,
   output logic                                    as_up_tready,
   input  logic [pDATA_WIDTH-1:0]                  aa_as_tdata,
   input  logic [pDATA_WIDTH/8-1:0]                aa_as_tstrb,
   input  logic [pDATA_WIDTH/8-1:0]                aa_as_tkeep,
   input  logic                                    aa_as_tlast,
   input  logic [1:0]                              aa_as_tuser,
   input  logic                                    aa_as_tvalid,
   output logic                                    as_aa_tready,
   output logic [pDATA_WIDTH-1:0]                  as_is_tdata,
   output logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] as_is_tupsb,
   output logic [pDATA_WIDTH/8-1:0]                as_is_tstrb,
   output logic [pDATA_WIDTH/8-1:0]                as_is_tkeep,
   output logic                                    as_is_tlast,
   output logic [1:0]                              as_is_tid,
   output logic [1:0]                              as_is_tuser,
   output logic                                    as_is_tvalid,
   input  logic                                    is_as_tready,
`ifdef AXIS_SW_RMT_DROP_CNT_EN
   output logic [15:0]                             ds_drop_cnt,
`endif
   output logic [$clog2(pFIFO_DEPTH):0]            ds_level
);

   localparam int SBW = pUSER_PROJECT_SIDEBAND_WIDTH;
   localparam int KW  = pDATA_WIDTH / 8;
   localparam int AW  = $clog2(pFIFO_DEPTH);
   localparam int CW  = $clog2(pMAX_BEAT + 1);
   localparam int EW  = 2 + 2 + 1 + KW + KW + SBW + pDATA_WIDTH;
   localparam logic [AW:0] FULL_LVL  = (AW + 1)'(pFIFO_DEPTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(pMAX_BEAT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      GRANT_UP = 2'b01,
      GRANT_AA = 2'b10
   } state_t;

   logic [EW-1:0]          mem [pFIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [AW:0]            level;
   logic                   push;
   logic                   pop;
   logic                   empty;
   logic                   drop;
   logic [pDATA_WIDTH-1:0] h_data;
   logic [SBW-1:0]         h_upsb;
   logic [KW-1:0]          h_strb;
   logic [KW-1:0]          h_keep;
   logic                   h_last;
   logic [1:0]             h_tid;
   logic [1:0]             h_user;

   state_t                 state;
   logic                   last_grant_aa;
   logic [CW-1:0]          beat_cnt;
   logic                   link_hs;
   logic                   release_now;

   assign as_is_tready = (level != FULL_LVL);
   assign ds_level     = level;
   assign push         = is_as_tvalid & as_is_tready;
   assign empty        = (level == '0);
   assign {h_user, h_tid, h_last, h_keep, h_strb, h_upsb, h_data} = mem[rd_ptr];

   // Head-of-line blocking: only the sink named by the head tid can pop; tid 11 pops itself.
   assign drop = !empty & (h_tid == 2'b11);
   assign pop  = !empty & (((h_tid == 2'b00) & up_as_tready) |
                           ((h_tid == 2'b01) & aa_as_tready) |
                           ((h_tid == 2'b10) & la_as_tready) |
                           (h_tid == 2'b11));

   always_ff @(posedge axis_clk) begin
      if (push) begin
         mem[wr_ptr] <= {is_as_tuser, is_as_tid, is_as_tlast, is_as_tkeep, is_as_tstrb, is_as_tupsb, is_as_tdata};
      end
   end

   always_ff @(posedge axis_clk or posedge axi_reset) begin
      if (axi_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + (AW + 1)'(1);
            2'b01:   level <= level - (AW + 1)'(1);
            default: level <= level;
         endcase
      end
   end

   always_comb begin
      as_up_tdata  = '0;
      as_up_tupsb  = '0;
      as_up_tstrb  = '0;
      as_up_tkeep  = '0;
      as_up_tlast  = 1'b0;
      as_up_tuser  = '0;
      as_up_tvalid = 1'b0;
      as_aa_tdata  = '0;
      as_aa_tstrb  = '0;
      as_aa_tkeep  = '0;
      as_aa_tlast  = 1'b0;
      as_aa_tuser  = '0;
      as_aa_tvalid = 1'b0;
      as_la_tdata  = '0;
      as_la_tstrb  = '0;
      as_la_tkeep  = '0;
      as_la_tlast  = 1'b0;
      as_la_tuser  = '0;
      as_la_tvalid = 1'b0;
      if (!empty) begin
         case (h_tid)
            2'b00: begin
               as_up_tdata  = h_data;
               as_up_tupsb  = h_upsb;
               as_up_tstrb  = h_strb;
               as_up_tkeep  = h_keep;
               as_up_tlast  = h_last;
               as_up_tuser  = h_user;
               as_up_tvalid = 1'b1;
            end
            2'b01: begin
               as_aa_tdata  = h_data;
               as_aa_tstrb  = h_strb;
               as_aa_tkeep  = h_keep;
               as_aa_tlast  = h_last;
               as_aa_tuser  = h_user;
               as_aa_tvalid = 1'b1;
            end
            2'b10: begin
               as_la_tdata  = h_data;
               as_la_tstrb  = h_strb;
               as_la_tkeep  = h_keep;
               as_la_tlast  = h_last;
               as_la_tuser  = h_user;
               as_la_tvalid = 1'b1;
            end
            default: begin
               as_la_tvalid = 1'b0;
            end
         endcase
      end
   end

`ifdef AXIS_SW_RMT_DROP_CNT_EN
   always_ff @(posedge axis_clk or posedge axi_reset) begin
      if (axi_reset) begin
         ds_drop_cnt <= '0;
      end else if (drop && (ds_drop_cnt != 16'hFFFF)) begin
         ds_drop_cnt <= ds_drop_cnt + 16'd1;
      end
   end
`endif

   assign link_hs     = as_is_tvalid & is_as_tready;
   assign release_now = link_hs & (as_is_tlast | (beat_cnt == LAST_CNT));

   // Grant goes to the source that did not win last time when both request.
   always_ff @(posedge axis_clk or posedge axi_reset) begin
      if (axi_reset) begin
         state         <= IDLE;
         last_grant_aa <= 1'b1;
         beat_cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (up_as_tvalid && aa_as_tvalid) begin
                  state <= last_grant_aa ? GRANT_UP : GRANT_AA;
               end else if (up_as_tvalid) begin
                  state <= GRANT_UP;
               end else if (aa_as_tvalid) begin
                  state <= GRANT_AA;
               end else begin
                  state <= IDLE;
               end
            end
            GRANT_UP, GRANT_AA: begin
               if (release_now) begin
                  state         <= IDLE;
                  last_grant_aa <= (state == GRANT_AA);
                  beat_cnt      <= '0;
               end else if (link_hs) begin
                  beat_cnt <= beat_cnt + CW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               beat_cnt <= '0;
            end
         endcase
      end
   end

   always_comb begin
      as_is_tdata  = '0;
      as_is_tupsb  = '0;
      as_is_tstrb  = '0;
      as_is_tkeep  = '0;
      as_is_tlast  = 1'b0;
      as_is_tid    = '0;
      as_is_tuser  = '0;
      as_is_tvalid = 1'b0;
      as_up_tready = 1'b0;
      as_aa_tready = 1'b0;
      case (state)
         GRANT_UP: begin
            as_is_tdata  = up_as_tdata;
            as_is_tupsb  = up_as_tupsb;
            as_is_tstrb  = up_as_tstrb;
            as_is_tkeep  = up_as_tkeep;
            as_is_tlast  = up_as_tlast;
            as_is_tid    = 2'b00;
            as_is_tuser  = up_as_tuser;
            as_is_tvalid = up_as_tvalid;
            as_up_tready = is_as_tready;
         end
         GRANT_AA: begin
            as_is_tdata  = aa_as_tdata;
            as_is_tstrb  = aa_as_tstrb;
            as_is_tkeep  = aa_as_tkeep;
            as_is_tlast  = aa_as_tlast;
            as_is_tid    = 2'b01;
            as_is_tuser  = aa_as_tuser;
            as_is_tvalid = aa_as_tvalid;
            as_aa_tready = is_as_tready;
         end
         default: begin
            as_is_tvalid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_axis_sw_remote.sv
// Randomized bench for axis_sw_remote against a queue-based reference model, plus directed scenarios.
module tb_axis_sw_remote;
   localparam int DEPTH = 8;
   localparam int MAXB  = 8;

   logic axis_clk = 1'b0;
   logic axi_reset;
   always #5 axis_clk = ~axis_clk;

   logic [31:0] is_as_tdata;  logic [4:0] is_as_tupsb; logic [3:0] is_as_tstrb, is_as_tkeep;
   logic is_as_tlast; logic [1:0] is_as_tid, is_as_tuser; logic is_as_tvalid, as_is_tready;
   logic [31:0] as_up_tdata;  logic [4:0] as_up_tupsb; logic [3:0] as_up_tstrb, as_up_tkeep;
   logic as_up_tlast; logic [1:0] as_up_tuser; logic as_up_tvalid, up_as_tready;
   logic [31:0] as_aa_tdata;  logic [3:0] as_aa_tstrb, as_aa_tkeep;
   logic as_aa_tlast; logic [1:0] as_aa_tuser; logic as_aa_tvalid, aa_as_tready;
   logic [31:0] as_la_tdata;  logic [3:0] as_la_tstrb, as_la_tkeep;
   logic as_la_tlast; logic [1:0] as_la_tuser; logic as_la_tvalid, la_as_tready;
   logic [31:0] up_as_tdata;  logic [4:0] up_as_tupsb; logic [3:0] up_as_tstrb, up_as_tkeep;
   logic up_as_tlast; logic [1:0] up_as_tuser; logic up_as_tvalid, as_up_tready;
   logic [31:0] aa_as_tdata;  logic [3:0] aa_as_tstrb, aa_as_tkeep;
   logic aa_as_tlast; logic [1:0] aa_as_tuser; logic aa_as_tvalid, as_aa_tready;
   logic [31:0] as_is_tdata;  logic [4:0] as_is_tupsb; logic [3:0] as_is_tstrb, as_is_tkeep;
   logic as_is_tlast; logic [1:0] as_is_tid, as_is_tuser; logic as_is_tvalid, is_as_tready;
   logic [3:0] ds_level;
`ifdef AXIS_SW_RMT_DROP_CNT_EN
   logic [15:0] ds_drop_cnt;
`endif

   axis_sw_remote dut (
      .axis_clk(axis_clk), .axi_reset(axi_reset),
      .is_as_tdata(is_as_tdata), .is_as_tupsb(is_as_tupsb), .is_as_tstrb(is_as_tstrb),
      .is_as_tkeep(is_as_tkeep), .is_as_tlast(is_as_tlast), .is_as_tid(is_as_tid),
      .is_as_tuser(is_as_tuser), .is_as_tvalid(is_as_tvalid), .as_is_tready(as_is_tready),
      .as_up_tdata(as_up_tdata), .as_up_tupsb(as_up_tupsb), .as_up_tstrb(as_up_tstrb),
      .as_up_tkeep(as_up_tkeep), .as_up_tlast(as_up_tlast), .as_up_tuser(as_up_tuser),
      .as_up_tvalid(as_up_tvalid), .up_as_tready(up_as_tready),
      .as_aa_tdata(as_aa_tdata), .as_aa_tstrb(as_aa_tstrb), .as_aa_tkeep(as_aa_tkeep),
      .as_aa_tlast(as_aa_tlast), .as_aa_tuser(as_aa_tuser), .as_aa_tvalid(as_aa_tvalid),
      .aa_as_tready(aa_as_tready),
      .as_la_tdata(as_la_tdata), .as_la_tstrb(as_la_tstrb), .as_la_tkeep(as_la_tkeep),
      .as_la_tlast(as_la_tlast), .as_la_tuser(as_la_tuser), .as_la_tvalid(as_la_tvalid),
      .la_as_tready(la_as_tready),
      .up_as_tdata(up_as_tdata), .up_as_tupsb(up_as_tupsb), .up_as_tstrb(up_as_tstrb),
      .up_as_tkeep(up_as_tkeep), .up_as_tlast(up_as_tlast), .up_as_tuser(up_as_tuser),
      .up_as_tvalid(up_as_tvalid), .as_up_tready(as_up_tready),
      .aa_as_tdata(aa_as_tdata), .aa_as_tstrb(aa_as_tstrb), .aa_as_tkeep(aa_as_tkeep),
      .aa_as_tlast(aa_as_tlast), .aa_as_tuser(aa_as_tuser), .aa_as_tvalid(aa_as_tvalid),
      .as_aa_tready(as_aa_tready),
      .as_is_tdata(as_is_tdata), .as_is_tupsb(as_is_tupsb), .as_is_tstrb(as_is_tstrb),
      .as_is_tkeep(as_is_tkeep), .as_is_tlast(as_is_tlast), .as_is_tid(as_is_tid),
      .as_is_tuser(as_is_tuser), .as_is_tvalid(as_is_tvalid), .is_as_tready(is_as_tready),
`ifdef AXIS_SW_RMT_DROP_CNT_EN
      .ds_drop_cnt(ds_drop_cnt),
`endif
      .ds_level(ds_level)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] d; logic [4:0] sb; logic [3:0] strb; logic [3:0] keep;
      logic last; logic [1:0] tid; logic [1:0] user;
   } beat_t;

   // Reference model: ingress FIFO as a queue; link owner 0=none,1=UP,2=AA.
   beat_t dq[$];
   int    m_owner, m_cnt, m_drops;
   bit    m_last_aa;

   // Stimulus knobs and directed-source bookkeeping.
   bit ing_manual, rdy_manual, src_pkt, aa_last_en, saw_dead;
   int pv_in = 50, pr = 70;
   int up_left, aa_left, up_sent, aa_sent, first_tid, first_up_aa;

   task automatic model_reset();
      dq.delete();
      m_owner = 0; m_cnt = 0; m_last_aa = 1'b1; m_drops = 0;
   endtask

   task automatic check_model();
      logic [63:0] e_up, e_aa, e_la, e_link;
      beat_t h;
      bit ne, pop, sv, sl;
      ne = (dq.size() > 0);
      e_up = '0; e_aa = '0; e_la = '0; e_link = '0;
      if (ne) begin
         h = dq[0];
         if (h.tid == 2'd0) e_up = 64'({1'b1, h.d, h.sb, h.strb, h.keep, h.last, h.user});
         if (h.tid == 2'd1) e_aa = 64'({1'b1, h.d, h.strb, h.keep, h.last, h.user});
         if (h.tid == 2'd2) e_la = 64'({1'b1, h.d, h.strb, h.keep, h.last, h.user});
      end
      chk("up_egress", 64'({as_up_tvalid, as_up_tdata, as_up_tupsb, as_up_tstrb, as_up_tkeep, as_up_tlast, as_up_tuser}), e_up);
      chk("aa_egress", 64'({as_aa_tvalid, as_aa_tdata, as_aa_tstrb, as_aa_tkeep, as_aa_tlast, as_aa_tuser}), e_aa);
      chk("la_egress", 64'({as_la_tvalid, as_la_tdata, as_la_tstrb, as_la_tkeep, as_la_tlast, as_la_tuser}), e_la);
      chk("ds_ctl", 64'({as_is_tready, ds_level}), 64'({dq.size() != DEPTH, 4'(dq.size())}));
      if (m_owner == 1)
         e_link = 64'({up_as_tvalid, up_as_tdata, up_as_tupsb, up_as_tstrb, up_as_tkeep, up_as_tlast,
                       2'b00, up_as_tuser, is_as_tready, 1'b0});
      else if (m_owner == 2)
         e_link = 64'({aa_as_tvalid, aa_as_tdata, 5'b0, aa_as_tstrb, aa_as_tkeep, aa_as_tlast,
                       2'b01, aa_as_tuser, 1'b0, is_as_tready});
      chk("link", 64'({as_is_tvalid, as_is_tdata, as_is_tupsb, as_is_tstrb, as_is_tkeep, as_is_tlast,
                       as_is_tid, as_is_tuser, as_up_tready, as_aa_tready}), e_link);
`ifdef AXIS_SW_RMT_DROP_CNT_EN
      chk("drop_cnt", 64'(ds_drop_cnt), 64'(m_drops));
`endif
      pop = ne && ((h.tid == 2'd3) || (h.tid == 2'd0 && up_as_tready) ||
                   (h.tid == 2'd1 && aa_as_tready) || (h.tid == 2'd2 && la_as_tready));
      if (is_as_tvalid && dq.size() != DEPTH) begin
         beat_t b;
         b.d = is_as_tdata; b.sb = is_as_tupsb; b.strb = is_as_tstrb; b.keep = is_as_tkeep;
         b.last = is_as_tlast; b.tid = is_as_tid; b.user = is_as_tuser;
         dq.push_back(b);
      end
      if (pop) begin
         if (h.tid == 2'd3 && m_drops < 65535) m_drops++;
         void'(dq.pop_front());
      end
      if (m_owner != 0) begin
         sv = (m_owner == 1) ? up_as_tvalid : aa_as_tvalid;
         sl = (m_owner == 1) ? up_as_tlast : aa_as_tlast;
         if (sv && is_as_tready) begin
            m_cnt++;
            if (sl || m_cnt == MAXB) begin
               m_last_aa = (m_owner == 2);
               m_owner = 0;
               m_cnt = 0;
            end
         end
      end else if (up_as_tvalid && aa_as_tvalid) begin
         m_owner = m_last_aa ? 1 : 2;
      end else if (up_as_tvalid) begin
         m_owner = 1;
      end else if (aa_as_tvalid) begin
         m_owner = 2;
      end
   endtask

   task automatic drive();
      if (!ing_manual) begin
         is_as_tvalid = ($urandom_range(99) < pv_in);
         is_as_tdata = $urandom; is_as_tupsb = 5'($urandom); is_as_tstrb = 4'($urandom);
         is_as_tkeep = 4'($urandom); is_as_tlast = 1'($urandom); is_as_tid = 2'($urandom);
         is_as_tuser = 2'($urandom);
      end
      if (!rdy_manual) begin
         up_as_tready = ($urandom_range(99) < pr); aa_as_tready = ($urandom_range(99) < pr);
         la_as_tready = ($urandom_range(99) < pr); is_as_tready = ($urandom_range(99) < pr);
      end
      up_as_tupsb = 5'($urandom); up_as_tstrb = 4'($urandom); up_as_tkeep = 4'($urandom);
      up_as_tuser = 2'($urandom); aa_as_tstrb = 4'($urandom); aa_as_tkeep = 4'($urandom);
      aa_as_tuser = 2'($urandom);
      if (src_pkt) begin
         up_as_tvalid = (up_left > 0); up_as_tlast = (up_left == 1);
         up_as_tdata = 32'hA000_0000 + 32'(up_sent);
         aa_as_tvalid = (aa_left > 0); aa_as_tlast = aa_last_en && (aa_left == 1);
         aa_as_tdata = 32'hB000_0000 + 32'(aa_sent);
      end else begin
         up_as_tvalid = ($urandom_range(99) < 60); up_as_tlast = ($urandom_range(99) < 30);
         up_as_tdata = $urandom;
         aa_as_tvalid = ($urandom_range(99) < 60); aa_as_tlast = ($urandom_range(99) < 30);
         aa_as_tdata = $urandom;
      end
   endtask

   task automatic tick();
      @(negedge axis_clk);
      check_model();
      if ((as_up_tvalid && as_up_tdata == 32'hDEAD) || (as_aa_tvalid && as_aa_tdata == 32'hDEAD) ||
          (as_la_tvalid && as_la_tdata == 32'hDEAD)) saw_dead = 1'b1;
      if (as_is_tvalid && is_as_tready && first_tid < 0) first_tid = int'(as_is_tid);
      if (src_pkt) begin
         if (up_as_tvalid && as_up_tready) begin
            if (first_up_aa < 0) first_up_aa = aa_sent;
            up_left--; up_sent++;
         end
         if (aa_as_tvalid && as_aa_tready) begin
            aa_left--; aa_sent++;
         end
      end
      @(posedge axis_clk);
      #1;
   endtask

   task automatic do_reset();
      axi_reset = 1'b1;
      #1;
      chk("rst_tvalid", 64'({as_up_tvalid, as_aa_tvalid, as_la_tvalid, as_is_tvalid}), 64'd0);
      chk("rst_level", 64'(ds_level), 64'd0);
      is_as_tvalid = 1'b0; up_as_tvalid = 1'b0; aa_as_tvalid = 1'b0;
      up_left = 0; aa_left = 0; up_sent = 0; aa_sent = 0; first_tid = -1; first_up_aa = -1;
      repeat (2) @(posedge axis_clk);
      #1;
      model_reset();
      axi_reset = 1'b0;
   endtask

   task automatic push_beat(input logic [1:0] tid, input logic [31:0] data);
      is_as_tvalid = 1'b1; is_as_tid = tid; is_as_tdata = data;
      drive();
      tick();
   endtask

   initial begin
      is_as_tvalid = 1'b0; is_as_tdata = '0; is_as_tupsb = '0; is_as_tstrb = '0; is_as_tkeep = '0;
      is_as_tlast = 1'b0; is_as_tid = '0; is_as_tuser = '0;
      up_as_tready = 1'b1; aa_as_tready = 1'b1; la_as_tready = 1'b1; is_as_tready = 1'b1;
      up_as_tvalid = 1'b0; aa_as_tvalid = 1'b0; up_as_tdata = '0; aa_as_tdata = '0;
      up_as_tlast = 1'b0; aa_as_tlast = 1'b0;
      ing_manual = 1'b1; rdy_manual = 1'b1; src_pkt = 1'b1; aa_last_en = 1'b1; saw_dead = 1'b0;
      do_reset();

      // Reset mid-packet: AA granted with 2 of 5 beats sent, three LA beats stuck in the FIFO.
      la_as_tready = 1'b0; aa_left = 5;
      for (int i = 0; i < 3; i++) push_beat(2'd2, 32'h100 + 32'(i));
      chk("mid_level", 64'(ds_level), 64'd3);
      chk("mid_aa_sent", 64'(aa_sent), 64'd2);
      do_reset();

      // Back-to-back tid 00/01/10 with all sinks ready.
      la_as_tready = 1'b1;
      push_beat(2'd0, 32'h11);
      chk("b2b_up", 64'({as_up_tvalid, as_up_tdata}), 64'({1'b1, 32'h11}));
      push_beat(2'd1, 32'h22);
      chk("b2b_aa", 64'({as_aa_tvalid, as_aa_tdata}), 64'({1'b1, 32'h22}));
      push_beat(2'd2, 32'h33);
      chk("b2b_la", 64'({as_la_tvalid, as_la_tdata}), 64'({1'b1, 32'h33}));
      is_as_tvalid = 1'b0;
      repeat (3) begin drive(); tick(); end

      // Fill: LA stalled, nine pushes offered, eight fit.
      la_as_tready = 1'b0;
      for (int i = 0; i < 9; i++) push_beat(2'd2, 32'h200 + 32'(i));
      chk("full_level", 64'(ds_level), 64'd8);
      chk("full_tready", 64'(as_is_tready), 64'd0);
      is_as_tvalid = 1'b0; la_as_tready = 1'b1;
      repeat (10) begin drive(); tick(); end
      chk("drain_level", 64'(ds_level), 64'd0);

      // UP and AA three-beat packets from reset.
      do_reset();
      up_left = 3; aa_left = 3; aa_last_en = 1'b1;
      repeat (12) begin drive(); tick(); end
      chk("rr_first_tid", 64'(first_tid), 64'd0);
      chk("rr_sent", 64'({16'(up_sent), 16'(aa_sent)}), 64'({16'd3, 16'd3}));

      // AA streams 12 beats without tlast; UP is waiting.
      do_reset();
      aa_left = 12; aa_last_en = 1'b0;
      drive(); tick();
      up_left = 3;
      repeat (30) begin drive(); tick(); end
      chk("maxbeat_aa_before_up", 64'(first_up_aa), 64'(MAXB));
      chk("maxbeat_sent", 64'({16'(up_sent), 16'(aa_sent)}), 64'({16'd3, 16'd12}));

      // tid 11 beat between two UP beats is discarded.
      do_reset();
      saw_dead = 1'b0;
      push_beat(2'd0, 32'h1);
      push_beat(2'd3, 32'hDEAD);
      push_beat(2'd0, 32'h2);
      is_as_tvalid = 1'b0;
      repeat (5) begin drive(); tick(); end
      chk("dead_seen", 64'(saw_dead), 64'd0);
`ifdef AXIS_SW_RMT_DROP_CNT_EN
      chk("drop_one", 64'(ds_drop_cnt), 64'd1);
`endif

      // Random traffic, normal and heavily back-pressured.
      do_reset();
      ing_manual = 1'b0; rdy_manual = 1'b0; src_pkt = 1'b0;
      pv_in = 50; pr = 70;
      repeat (3000) begin drive(); tick(); end
      pv_in = 90; pr = 30;
      repeat (1500) begin drive(); tick(); end

`ifdef AXIS_SW_RMT_DROP_CNT_EN
      do_reset();
      ing_manual = 1'b1; rdy_manual = 1'b1; src_pkt = 1'b1;
      is_as_tvalid = 1'b1; is_as_tid = 2'd3;
      repeat (70010) begin drive(); tick(); end
      chk("drop_sat", 64'(ds_drop_cnt), 64'hFFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
